// File: rtl/lstm_fixed_pkg.sv
// Shared fixed-point types, defaults and helpers for the LSTM gate datapaths.
// Helpers work on 64-bit signed values so callers of any width <= 32 can share them.
package lstm_fixed_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int FRACT_WIDTH_DEF = 8;
    localparam int ACC_WIDTH_DEF   = 24;

    typedef logic signed [DATA_WIDTH_DEF-1:0] fx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Full-precision product, then arithmetic shift back to the operand's Q format.
    function automatic logic signed [63:0] fx_mul_shift(input logic signed [63:0] a,
                                                        input logic signed [63:0] b,
                                                        input int fract);
        return (a * b) >>> fract;
    endfunction

    // Clamp to the signed range of a w-bit value.
    function automatic logic signed [63:0] fx_sat(input logic signed [63:0] v,
                                                  input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/grad_accumulator.sv
// One wrapping signed accumulator with synchronous clear and a saturated view
// narrowed to the data width.
module grad_accumulator
    import lstm_fixed_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  en,
    input  logic [ACC_WIDTH-1:0]  addend,
    output logic [DATA_WIDTH-1:0] sat_out
);

    logic [ACC_WIDTH-1:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (en)
            acc <= acc + addend;
    end

    assign sat_out = DATA_WIDTH'(fx_sat(64'($signed(acc)), DATA_WIDTH));

endmodule

// File: rtl/two_mult_add_backprop.sv
// Backward pass of the two-input gate MAC: streams dX/dM per sample and
// accumulates dW0/dW1/db over a sequence, presenting them until acknowledged.
//
// state | meaning
// IDLE  | accumulators zero, waiting for first sample of a sequence
// ACCUM | mid-sequence, accumulating parameter gradients
// DONE  | sequence closed, gradients presented until grad_ack
module two_mult_add_backprop
    import lstm_fixed_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FRACT_WIDTH = FRACT_WIDTH_DEF,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [DATA_WIDTH-1:0] d_out,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] m,
    input  logic [DATA_WIDTH-1:0] w0,
    input  logic [DATA_WIDTH-1:0] w1,
    output logic [DATA_WIDTH-1:0] dx,
    output logic [DATA_WIDTH-1:0] dm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] grad_dw0,
    output logic [DATA_WIDTH-1:0] grad_dw1,
    output logic [DATA_WIDTH-1:0] grad_db,
    output logic                  grad_valid,
    input  logic                  grad_ack
);

    state_t state;
    state_t state_next;

    logic accept;
    logic clear;

    logic signed [63:0] d_ext;
    logic signed [63:0] x_ext;
    logic signed [63:0] m_ext;
    logic signed [63:0] w0_ext;
    logic signed [63:0] w1_ext;

    logic [ACC_WIDTH-1:0] add_dw0;
    logic [ACC_WIDTH-1:0] add_dw1;
    logic [ACC_WIDTH-1:0] add_db;

    assign d_ext  = 64'($signed(d_out));
    assign x_ext  = 64'($signed(x));
    assign m_ext  = 64'($signed(m));
    assign w0_ext = 64'($signed(w0));
    assign w1_ext = 64'($signed(w1));

    assign in_ready   = (state != DONE) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign grad_valid = (state == DONE);
    assign clear      = (state == DONE) && grad_ack;

    assign add_dw0 = ACC_WIDTH'(fx_mul_shift(d_ext, x_ext, FRACT_WIDTH));
    assign add_dw1 = ACC_WIDTH'(fx_mul_shift(d_ext, m_ext, FRACT_WIDTH));
    assign add_db  = ACC_WIDTH'(d_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = in_last ? DONE : ACCUM;
            ACCUM:   if (accept && in_last) state_next = DONE;
            DONE:    if (grad_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // dx/dm wrap to the data width, matching the forward gate's rounding rule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx        <= '0;
            dm        <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            dx        <= DATA_WIDTH'(fx_mul_shift(w0_ext, d_ext, FRACT_WIDTH));
            dm        <= DATA_WIDTH'(fx_mul_shift(w1_ext, d_ext, FRACT_WIDTH));
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    grad_accumulator #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_acc_dw0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .en(accept),
        .addend(add_dw0), .sat_out(grad_dw0)
    );

    grad_accumulator #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_acc_dw1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .en(accept),
        .addend(add_dw1), .sat_out(grad_dw1)
    );

    grad_accumulator #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_acc_db (
        .clk(clk), .rst_n(rst_n), .clear(clear), .en(accept),
        .addend(add_db), .sat_out(grad_db)
    );

endmodule

// File: tb/tb_two_mult_add_backprop.sv
// Self-checking bench for two_mult_add_backprop: directed cases plus randomized
// sequences, checked every cycle against an arithmetic reference model.
module tb_two_mult_add_backprop;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last;
    logic [15:0] d_out, x, m, w0, w1;
    logic [15:0] dx, dm;
    logic        out_valid, out_ready;
    logic [15:0] grad_dw0, grad_dw1, grad_db;
    logic        grad_valid, grad_ack;

    int n_tests = 0;
    int n_fail  = 0;
    int ready_mode = 1;   // 0 random, 1 always ready, 2 stalled

    // reference model state
    bit     m_ov, m_done;
    logic [15:0] m_dx, m_dm;
    longint s_dw0, s_dw1, s_db;

    two_mult_add_backprop dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .d_out(d_out), .x(x), .m(m), .w0(w0), .w1(w1),
        .dx(dx), .dm(dm), .out_valid(out_valid), .out_ready(out_ready),
        .grad_dw0(grad_dw0), .grad_dw1(grad_dw1), .grad_db(grad_db),
        .grad_valid(grad_valid), .grad_ack(grad_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Signed Q8.8 product as floor((a*b)/256).
    function automatic int ref_mul(input logic [15:0] a, input logic [15:0] b);
        int p, q;
        p = int'($signed(a)) * int'($signed(b));
        q = p / 256;
        if ((p % 256 != 0) && (p < 0)) q = q - 1;
        return q;
    endfunction

    // Wrap the exact sum to 24 bits, then clamp to 16-bit signed range.
    function automatic logic [15:0] ref_sat(input longint s);
        longint w;
        w = s & 64'hFF_FFFF;
        if (w >= 64'sd8388608) w = w - 64'sd16777216;
        if (w > 32767) return 16'h7FFF;
        if (w < -32768) return 16'h8000;
        return w[15:0];
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = ($urandom % 3) != 0;
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        bit exp_ir, old_done;
        int p;
        if (!rst_n) begin
            m_ov = 0; m_done = 0; m_dx = '0; m_dm = '0;
            s_dw0 = 0; s_dw1 = 0; s_db = 0;
        end else begin
            exp_ir = !m_done && (!m_ov || out_ready);
            check("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
            check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
            if (m_ov) begin
                check("dx", {16'b0, dx}, {16'b0, m_dx});
                check("dm", {16'b0, dm}, {16'b0, m_dm});
            end
            check("grad_valid", {31'b0, grad_valid}, {31'b0, m_done});
            if (m_done) begin
                check("grad_dw0", {16'b0, grad_dw0}, {16'b0, ref_sat(s_dw0)});
                check("grad_dw1", {16'b0, grad_dw1}, {16'b0, ref_sat(s_dw1)});
                check("grad_db",  {16'b0, grad_db},  {16'b0, ref_sat(s_db)});
            end
            old_done = m_done;
            if (in_valid && exp_ir) begin
                p = ref_mul(w0, d_out); m_dx = p[15:0];
                p = ref_mul(w1, d_out); m_dm = p[15:0];
                m_ov = 1;
                s_dw0 += ref_mul(d_out, x);
                s_dw1 += ref_mul(d_out, m);
                s_db  += longint'($signed(d_out));
                if (in_last) m_done = 1;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (old_done && grad_ack) begin
                m_done = 0; s_dw0 = 0; s_dw1 = 0; s_db = 0;
            end
        end
    end

    // Present one sample and hold it until accepted (bounded).
    task automatic send(input logic [15:0] d, input logic [15:0] xi, input logic [15:0] mi,
                        input logic [15:0] a0, input logic [15:0] a1, input logic last);
        bit taken = 0;
        d_out = d; x = xi; m = mi; w0 = a0; w1 = a1; in_last = last; in_valid = 1'b1;
        for (int i = 0; i < 60 && !taken; i++) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
        end
        if (!taken) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_grad();
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = grad_valid;
        end
        if (!seen) check("grad_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic ack_grad();
        grad_ack = 1'b1;
        @(posedge clk); #1;
        grad_ack = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] dv [4];
        logic [15:0] sum_db;
        rst_n = 1'b0; in_valid = 0; in_last = 0; grad_ack = 0; out_ready = 1;
        d_out = 0; x = 0; m = 0; w0 = 0; w1 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_grad_valid", {31'b0, grad_valid}, 0);
        check("rst_dx", {16'b0, dx}, 0);
        check("rst_grad_dw0", {16'b0, grad_dw0}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic
        ready_mode = 1;
        send(16'h0100, 16'h0300, 16'h0040, 16'h0200, 16'h0080, 1'b1);
        check("basic_dx", {16'b0, dx}, 32'h0200);
        check("basic_dm", {16'b0, dm}, 32'h0080);
        wait_grad();
        check("basic_dw0", {16'b0, grad_dw0}, 32'h0300);
        check("basic_dw1", {16'b0, grad_dw1}, 32'h0040);
        check("basic_db",  {16'b0, grad_db},  32'h0100);
        ack_grad();

        // signed
        send(16'hFF00, 16'h0100, 16'h0000, 16'h0200, 16'h0000, 1'b1);
        check("signed_dx", {16'b0, dx}, 32'hFE00);
        wait_grad();
        check("signed_dw0", {16'b0, grad_dw0}, 32'hFF00);
        check("signed_db",  {16'b0, grad_db},  32'hFF00);
        ack_grad();

        // saturation, both directions
        send(16'h7F00, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        send(16'h7F00, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        wait_grad();
        check("sat_pos_dw0", {16'b0, grad_dw0}, 32'h7FFF);
        ack_grad();
        send(16'h8000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        send(16'h8000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        wait_grad();
        check("sat_neg_dw0", {16'b0, grad_dw0}, 32'h8000);
        ack_grad();

        // backpressure: 4 back-to-back samples against a stalled sink
        dv[0] = 16'h0110; dv[1] = 16'hFF20; dv[2] = 16'h0033; dv[3] = 16'h0404;
        sum_db = dv[0] + dv[1] + dv[2] + dv[3];
        ready_mode = 2;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(dv[i], 16'h0100 + 16'(i), 16'h0020, 16'h0180, 16'hFF80, i == 3);
            end
            begin
                repeat (4) @(posedge clk);
                ready_mode = 1;
            end
        join
        wait_grad();
        check("bp_db_sum", {16'b0, grad_db}, {16'b0, sum_db});

        // DONE refuses input and ignores it; ack clears for the next sequence
        d_out = 16'h0700; in_last = 1'b1; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("done_hold_db", {16'b0, grad_db}, {16'b0, sum_db});
        ack_grad();
        send(16'h0200, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1);
        wait_grad();
        check("fresh_db",  {16'b0, grad_db},  32'h0200);
        check("fresh_dw0", {16'b0, grad_dw0}, 32'h0200);
        ack_grad();

        // reset mid-sequence
        send(16'h0300, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0);
        send(16'h0300, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 0);
        check("mid_rst_dx", {16'b0, dx}, 0);
        check("mid_rst_grad_db", {16'b0, grad_db}, 0);
        check("mid_rst_grad_dw0", {16'b0, grad_dw0}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        send(16'h0080, 16'h0200, 16'h0400, 16'h0100, 16'h0100, 1'b1);
        wait_grad();
        check("post_rst_db",  {16'b0, grad_db},  32'h0080);
        check("post_rst_dw1", {16'b0, grad_dw1}, 32'h0200);
        ack_grad();

        // randomized sequences
        ready_mode = 0;
        for (int s = 0; s < 40; s++) begin
            int len;
            len = 1 + ($urandom % 6);
            for (int k = 0; k < len; k++) begin
                send(16'($urandom), 16'($urandom), 16'($urandom),
                     16'($urandom), 16'($urandom), k == len - 1);
                if ($urandom % 3 == 0) begin
                    in_last = 1'b1;
                    repeat (1 + $urandom % 2) @(posedge clk);
                    #1;
                end
            end
            wait_grad();
            if ($urandom % 2 == 0) begin
                in_valid = 1'b1;
                repeat ($urandom % 3) @(posedge clk);
                #1;
            end
            ack_grad();
        end

        ready_mode = 1;
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/two_mult_add_backprop.md
Name: two_mult_add_backprop

Overview:
- Backward-pass counterpart of the LSTM two-input gate MAC, where the forward gate computes out = W0*X + W1*M + b in signed fixed point.
- Per accepted sample it takes the upstream gradient dOut and emits input gradients dX = W0*dOut and dM = W1*dOut on a streaming handshake.
- Over a sequence (BPTT window) it accumulates the parameter gradients dW0 += dOut*X, dW1 += dOut*M and db += dOut.
- At sequence end it presents the accumulated gradients until they are acknowledged. It sits between the gate's backward stream and the weight-update logic.

Parameters:
- DATA_WIDTH, 16, width of all signed fixed-point data ports (Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH).
- FRACT_WIDTH, 8, fractional bits.
- ACC_WIDTH, 24, internal signed accumulator width; must be >= DATA_WIDTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample this cycle.
- in_last  in  1  sample is the final one of the sequence.
- d_out  in  DATA_WIDTH  upstream gradient dOut.
- x  in  DATA_WIDTH  forward input X saved for this sample.
- m  in  DATA_WIDTH  forward recurrent input M saved for this sample.
- w0  in  DATA_WIDTH  weight W0; sampled on accept.
- w1  in  DATA_WIDTH  weight W1; sampled on accept.
- dx  out  DATA_WIDTH  gradient w.r.t. X.
- dm  out  DATA_WIDTH  gradient w.r.t. M.
- out_valid  out  1  dx/dm valid.
- out_ready  in  1  downstream accepts dx/dm.
- grad_dw0  out  DATA_WIDTH  accumulated dW0, saturated.
- grad_dw1  out  DATA_WIDTH  accumulated dW1, saturated.
- grad_db  out  DATA_WIDTH  accumulated db, saturated.
- grad_valid  out  1  sequence gradients valid.
- grad_ack  in  1  consumer has taken the gradients.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, accumulators=0, out_valid=0, grad_valid=0, and dx, dm, grad_* = 0. A reset mid-sequence discards all partial sums.
- Accept condition: in_valid && in_ready. Define in_ready = (state != DONE) && (!out_valid || out_ready).
- Arithmetic: all operands are two's-complement signed.
  - Each product is the full 2*DATA_WIDTH-bit signed product, arithmetically shifted right by FRACT_WIDTH.
  - For dx/dm the shifted product is truncated to the low DATA_WIDTH bits (wraps, same rule as the forward gate).
  - For accumulation the shifted product is sign-extended or truncated to ACC_WIDTH, and the accumulators wrap at ACC_WIDTH.
  - The grad_* outputs are the accumulators saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Sample path: on accept, dx/dm are registered and out_valid=1 the next cycle (latency 1). dx/dm hold while out_valid && !out_ready. out_valid clears on out_ready without a new accept. Back-to-back accepts sustain 1 sample per cycle.
- Accumulation: on accept, acc_dw0 += d_out*x, acc_dw1 += d_out*m, acc_db += sext(d_out), all in the same cycle.
- FSM:
  - IDLE: accumulators are zero. Accept with !in_last -> ACCUM. Accept with in_last -> DONE.
  - ACCUM: accept with in_last -> DONE; otherwise stay.
  - DONE: grad_valid=1 and grad_* are stable; in_ready=0. The dx/dm of the last sample still drain normally.
  - In DONE, grad_ack=1 -> IDLE with accumulators cleared and grad_valid=0 on the next edge.
  - grad_ack is ignored outside DONE.
- Edge cases:
  - A single-sample sequence (first sample carries in_last) is legal.
  - in_last with in_valid=0 has no effect.
  - When DONE is entered while out_valid is stalled, grad_valid rises regardless of the dx/dm drain.

Decomposition:
- Shared package lstm_fixed_pkg holds DATA_WIDTH/FRACT_WIDTH defaults, the signed fixed-point typedef, and the functions fx_mul_shift (multiply plus arithmetic shift) and fx_sat (saturate ACC_WIDTH to DATA_WIDTH).
- The package also holds the FSM state enum (IDLE, ACCUM, DONE).
- One sub-module, grad_accumulator, which is one signed ACC_WIDTH accumulator with clear and a saturated output. It is instantiated three times.

Test Plan:
- Basic: w0=0x0200, w1=0x0080, d_out=0x0100, x=0x0300, m=0x0040, in_last=1 -> dx=0x0200, dm=0x0080 one cycle later. Then grad_valid=1 with grad_dw0=0x0300, grad_dw1=0x0040, grad_db=0x0100.
- Signed: d_out=0xFF00 (-1.0), w0=0x0200, x=0x0100, 1 sample -> dx=0xFE00, grad_dw0=0xFF00, grad_db=0xFF00.
- Saturation: 2 samples with d_out=0x7F00, x=0x0100 -> acc_dw0=0xFE00, grad_dw0=0x7FFF. Same with d_out=0x8000 -> grad_dw0=0x8000.
- Backpressure: 4 back-to-back samples with out_ready=0 for 3 cycles -> in_ready drops, dx/dm hold stable, no sample is lost or duplicated, and grad_db equals the sum of all 4 d_out.
- Handshake: in DONE, assert in_valid -> not accepted. Pulse grad_ack -> IDLE. The next sequence's grads exclude prior sums.
- Reset mid-sequence: rst_n=0 after 2 of 4 samples -> all outputs 0 immediately. A new 1-sample sequence yields grads from that sample only.
